axi_master_ctrl: RTL and testbench
==================================

AXI_MASTER_CTRL -- requirements
Module: axi_master_ctrl

Interface
- REQ-001 Parameter ADDR_W, default 32: address width; drives rd_addr, wr_addr, araddr and awaddr.
- REQ-002 Parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
- REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
- REQ-004 Ports, one per line (name, direction, width, meaning):
  - aclk  in  1  clock; all transfers are timed on its rising edge.
  - areset  in  1  asynchronous active-high reset.
  - start_read  in  1  read request; level signal, held until cmd_ack.
  - start_write  in  1  write request; level signal, held until cmd_ack.
  - rd_addr  in  ADDR_W  read start address.
  - rd_len  in  8  read beats minus one.
  - wr_addr  in  ADDR_W  write start address.
  - wr_len  in  8  write beats minus one.
  - cmd_size  in  3  AxSIZE value for both directions.
  - cmd_burst  in  2  AxBURST value for both directions.
  - cmd_ack  out  1  one-cycle pulse in the grant cycle.
  - busy  out  1  high whenever the state is not IDLE.
  - done  out  1  one-cycle pulse at transaction end.
  - done_resp  out  2  response reported with done.
  - done_is_write  out  1  direction of the completed transaction.
  - wr_data  in  DATA_W  local write data.
  - wr_strb  in  DATA_W/8  local write strobes.
  - wr_valid  in  1  local write data valid.
  - wr_ready  out  1  local write data ready.
  - rd_data  out  DATA_W  local read data.
  - rd_valid  out  1  local read data valid.
  - rd_ready  in  1  local read data ready.
  - rd_last  out  1  last read beat.
  - AXI4 master signals: araddr, arvalid, arlen, arsize, arburst, arready, rdata, rresp, rvalid, rready, rlast, awaddr, awvalid, awlen, awsize, awburst, awready, wdata, wstrb, wvalid, wready, wlast, bresp, bvalid, bready. Directions and widths are per AXI4 master: len 8, size 3, burst 2, resp 2.

Function
- REQ-005 FSM states: IDLE, AR, R, AW, W, B. Only one transaction is outstanding at a time.
- REQ-006 Grant cycle (IDLE with any start asserted):
  - pulse cmd_ack;
  - register the selected addr, len, cmd_size and cmd_burst;
  - go to AR (read) or AW (write).
- REQ-007 Arbitration when both starts are asserted in the same cycle: per REQ-024/025.
- REQ-008 AR state:
  - arvalid=1 from the first cycle after grant;
  - AR payload stays stable until arready is sampled high;
  - on the handshake, go to R.
- REQ-009 R state:
  - rready = rd_ready; rd_valid = rvalid; rd_data = rdata; rd_last = rlast (combinational passthrough).
- REQ-010 Read termination: a beat with rvalid & rready & rlast SHALL cause:
  - done=1 on the next cycle;
  - done_is_write=0;
  - state returns to IDLE.
  - Termination is by rlast only; the beat counter is ignored.
- REQ-011 done_resp for reads: the first non-OKAY rresp of the burst, otherwise OKAY (2'b00).
- REQ-012 AW state:
  - awvalid=1 from the first cycle after grant;
  - payload stable until awready;
  - on the handshake, go to W.
- REQ-013 W state passthrough: wvalid = wr_valid; wr_ready = wready; wdata = wr_data; wstrb = wr_strb.
- REQ-014 Write beat counter:
  - 8-bit, cleared on entry to W;
  - increments on each wvalid & wready;
  - wlast = (count == registered len).
- REQ-015 len=255 SHALL produce exactly 256 beats with no counter wrap before wlast.
- REQ-016 The handshake of the wlast beat SHALL move the FSM to B. wvalid and wr_ready are 0 outside W.
- REQ-017 B state:
  - bready=1;
  - on bvalid: done=1 on the next cycle, done_resp=bresp, done_is_write=1, go to IDLE.
- REQ-018 Start requests arriving while busy are not acknowledged and are evaluated on the first IDLE cycle. A back-to-back transaction is granted in the cycle done pulses.
- REQ-019 rready, bready, arvalid and awvalid SHALL be 0 in all states other than their own.

Reset
- REQ-020 areset SHALL immediately (asynchronously) force:
  - state IDLE;
  - all valid, ready, last and pulse outputs to 0;
  - addresses and lengths to 0;
  - done_resp 0; counter 0; round-robin pointer to "write last".
- REQ-021 Reset mid-burst abandons the transaction. No done is issued.
- REQ-022 After areset deasserts, the first grant is possible on the next rising edge.

Configuration
- REQ-023 Macro AXI_MASTER_CTRL_RR_EN selects the arbitration policy.
- REQ-024 With AXI_MASTER_CTRL_RR_EN defined: round-robin. When both starts are high, grant the direction not granted last. The pointer updates on every grant; after reset, read wins first.
- REQ-025 Without AXI_MASTER_CTRL_RR_EN: fixed priority, read always wins. No pointer register exists.

Verification
- REQ-026 Read, rd_addr=0x100, rd_len=3, arready delayed 2 cycles -> arvalid held 3 cycles with araddr=0x100 and arlen=3; 4 beats forwarded; done pulse one cycle after the rlast beat; done_resp=0.
- REQ-027 Write, wr_len=255, wr_valid toggling -> exactly 256 W handshakes; wlast only on the 256th; bresp=2 gives done_resp=2 and done_is_write=1.
- REQ-028 start_read and start_write held high together for 3 transactions:
  - with RR_EN -> order R, W, R;
  - without RR_EN -> R, R, R.
- REQ-029 areset asserted during the 2nd beat of a 4-beat write -> wvalid, awvalid and busy are 0 in the same cycle; no done; a new read is granted cleanly after release.
- REQ-030 Read with rresp sequence OKAY, SLVERR, DECERR, OKAY -> done_resp=2 (SLVERR, the first non-OKAY).

Source files
------------

// File: rtl/axi_master_ctrl.sv
// Single-outstanding AXI4 burst master: local read/write commands become AR/R or AW/W/B bursts.
// Define AXI_MASTER_CTRL_RR_EN for round-robin read/write arbitration; otherwise read has fixed priority.
module axi_master_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                areset,
    // local command side
    input  logic                start_read,
    input  logic                start_write,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [7:0]          rd_len,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [7:0]          wr_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    output logic                cmd_ack,
    output logic                busy,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                done_is_write,
    // local data side
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                rd_last,
    // AXI4 read channels
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    input  logic                rlast,
    // AXI4 write channels
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    output logic                wlast,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_cnt_q;
    logic [1:0]        rresp_acc_q;
    logic              done_q;
    logic [1:0]        done_resp_q;
    logic              done_is_write_q;

    logic grant, grant_write;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    // The grant is combinational so cmd_ack lands in the IDLE cycle itself; reset masks it at once.
    assign grant = (state_q == IDLE) && (start_read || start_write) && !areset;

`ifdef AXI_MASTER_CTRL_RR_EN
    logic last_write_q;

    // On contention the direction not granted last wins; reset makes "write last" so read goes first.
    assign grant_write = start_write && (!start_read || !last_write_q);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            last_write_q <= 1'b1;
        else if (grant)
            last_write_q <= grant_write;
    end
`else
    assign grant_write = start_write && !start_read;
`endif

    assign ar_hs = (state_q == AR) && arready;
    assign r_hs  = (state_q == R)  && rvalid && rd_ready;
    assign aw_hs = (state_q == AW) && awready;
    assign w_hs  = (state_q == W)  && wr_valid && wready;
    assign b_hs  = (state_q == B)  && bvalid;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cmd_ack  = grant;
        busy     = (state_q != IDLE);
        arvalid  = 1'b0;
        rready   = 1'b0;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        wr_ready = 1'b0;
        wlast    = 1'b0;
        bready   = 1'b0;
        case (state_q)
            IDLE: if (grant) state_d = grant_write ? AW : AR;
            AR: begin
                arvalid = 1'b1;
                if (ar_hs) state_d = R;
            end
            R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = rlast;
                if (r_hs && rlast) state_d = IDLE;
            end
            AW: begin
                awvalid = 1'b1;
                if (aw_hs) state_d = W;
            end
            W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = (beat_cnt_q == len_q);
                if (w_hs && wlast) state_d = B;
            end
            B: begin
                bready = 1'b1;
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            beat_cnt_q      <= '0;
            rresp_acc_q     <= '0;
            done_q          <= 1'b0;
            done_resp_q     <= '0;
            done_is_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (grant) begin
                addr_q      <= grant_write ? wr_addr : rd_addr;
                len_q       <= grant_write ? wr_len : rd_len;
                size_q      <= cmd_size;
                burst_q     <= cmd_burst;
                rresp_acc_q <= 2'b00;
            end
            if (aw_hs)
                beat_cnt_q <= 8'd0;
            else if (w_hs)
                beat_cnt_q <= beat_cnt_q + 8'd1;
            // Keep the first error of the burst; later beats cannot overwrite it.
            if (r_hs) begin
                if (rresp_acc_q == 2'b00)
                    rresp_acc_q <= rresp;
                if (rlast) begin
                    done_q          <= 1'b1;
                    done_is_write_q <= 1'b0;
                    done_resp_q     <= (rresp_acc_q != 2'b00) ? rresp_acc_q : rresp;
                end
            end
            if (b_hs) begin
                done_q          <= 1'b1;
                done_is_write_q <= 1'b1;
                done_resp_q     <= bresp;
            end
        end
    end

    assign done          = done_q;
    assign done_resp     = done_resp_q;
    assign done_is_write = done_is_write_q;

    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = burst_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awburst = burst_q;

    assign rd_data = rdata;
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Directed bench for axi_master_ctrl: read/write bursts, error responses, arbitration, mid-burst reset.
module tb_axi_master_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              aclk, areset;
    logic              start_read, start_write;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [7:0]        rd_len, wr_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;
    logic              cmd_ack, busy, done, done_is_write;
    logic [1:0]        done_resp;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic              wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, awsize;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic [DATA_W-1:0] rdata, wdata;
    logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]        wstrb;

    int checks = 0;
    int failures = 0;

    axi_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .areset(areset),
        .start_read(start_read), .start_write(start_write),
        .rd_addr(rd_addr), .rd_len(rd_len), .wr_addr(wr_addr), .wr_len(wr_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .cmd_ack(cmd_ack), .busy(busy), .done(done), .done_resp(done_resp),
        .done_is_write(done_is_write),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .araddr(araddr), .arvalid(arvalid), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .awaddr(awaddr), .awvalid(awvalid), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic idle_inputs();
        start_read = 0; start_write = 0;
        rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
        cmd_size = 3'd2; cmd_burst = 2'd1;
        wr_data = '0; wr_strb = 4'hF; wr_valid = 0; rd_ready = 0;
        arready = 0; rdata = '0; rresp = 0; rvalid = 0; rlast = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic test_reset();
        areset = 1; start_read = 1; start_write = 1;
        repeat (2) @(negedge aclk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (cmd_ack !== 1'b0) begin failures++; $display("FAIL rst_cmd_ack got=%0b exp=0", cmd_ack); end
        checks++; if (arvalid !== 1'b0 || awvalid !== 1'b0) begin failures++; $display("FAIL rst_axvalid got=%0b%0b exp=00", arvalid, awvalid); end
        checks++; if (wvalid !== 1'b0 || rready !== 1'b0 || bready !== 1'b0) begin failures++; $display("FAIL rst_handshake got=%0b%0b%0b exp=000", wvalid, rready, bready); end
        checks++; if (done !== 1'b0 || done_resp !== 2'b00) begin failures++; $display("FAIL rst_done got=%0b/%0h exp=0/0", done, done_resp); end
        checks++; if (araddr !== '0 || arlen !== 8'd0) begin failures++; $display("FAIL rst_addr got=%0h/%0h exp=0/0", araddr, arlen); end
        @(negedge aclk);
        start_read = 0; start_write = 0; areset = 0;
    endtask

    // One read burst of up to 4 beats; beat i uses resps[2i+:2]; a stall cycle precedes beat 1.
    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                            input logic [7:0] resps, input logic [1:0] exp_resp, input string tag);
        @(negedge aclk);
        rd_addr = addr; rd_len = len; cmd_size = 3'd2; cmd_burst = 2'd1; start_read = 1;
        #1;
        checks++; if (cmd_ack !== 1'b1) begin failures++; $display("FAIL %s_cmd_ack got=%0b exp=1", tag, cmd_ack); end
        @(negedge aclk);
        start_read = 0; rd_addr = '0; rd_len = '0;
        for (int c = 0; c <= ar_delay; c++) begin
            arready = (c == ar_delay);
            #1;
            checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL %s_arvalid cyc%0d got=%0b exp=1", tag, c, arvalid); end
            checks++; if (araddr !== addr || arlen !== len) begin failures++; $display("FAIL %s_ar_payload got=%0h/%0h exp=%0h/%0h", tag, araddr, arlen, addr, len); end
            if (c < ar_delay) @(negedge aclk);
        end
        checks++; if (arsize !== 3'd2 || arburst !== 2'd1) begin failures++; $display("FAIL %s_ar_size_burst got=%0h/%0h exp=2/1", tag, arsize, arburst); end
        @(negedge aclk);
        arready = 0;
        #1;
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL %s_arvalid_after got=%0b exp=0", tag, arvalid); end
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 1) begin
                rvalid = 1; rd_ready = 0; rlast = (len == 8'd1); rdata = 32'hDEAD_0000;
                #1;
                checks++; if (rready !== 1'b0 || rd_valid !== 1'b1) begin failures++; $display("FAIL %s_stall got=%0b%0b exp=01", tag, rready, rd_valid); end
                @(negedge aclk);
            end
            rvalid = 1; rd_ready = 1; rlast = (i == int'(len));
            rdata = 32'hA000_0000 + i; rresp = resps[2*i +: 2];
            #1;
            checks++; if (rd_valid !== 1'b1 || rready !== 1'b1) begin failures++; $display("FAIL %s_beat%0d_valid got=%0b%0b exp=11", tag, i, rd_valid, rready); end
            checks++; if (rd_data !== 32'hA000_0000 + i) begin failures++; $display("FAIL %s_beat%0d_data got=%0h exp=%0h", tag, i, rd_data, 32'hA000_0000 + i); end
            checks++; if (rd_last !== (i == int'(len))) begin failures++; $display("FAIL %s_beat%0d_last got=%0b exp=%0b", tag, i, rd_last, i == int'(len)); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_beat%0d_early_done got=%0b exp=0", tag, i, done); end
            @(negedge aclk);
        end
        rvalid = 0; rlast = 0; rd_ready = 0; rresp = 0;
        #1;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done got=%0b exp=1", tag, done); end
        checks++; if (done_is_write !== 1'b0) begin failures++; $display("FAIL %s_done_dir got=%0b exp=0", tag, done_is_write); end
        checks++; if (done_resp !== exp_resp) begin failures++; $display("FAIL %s_done_resp got=%0h exp=%0h", tag, done_resp, exp_resp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%0b exp=0", tag, busy); end
        @(negedge aclk);
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%0b exp=0", tag, done); end
    endtask

    task automatic test_read();
        run_read(32'h100, 8'd3, 2, 8'h00, 2'b00, "rd");
    endtask

    // OKAY, SLVERR, DECERR, OKAY: the first error (SLVERR) must be reported.
    task automatic test_read_resp();
        run_read(32'h180, 8'd3, 0, 8'b00_11_10_00, 2'b10, "rresp");
    endtask

    task automatic test_write_256();
        int dut_hs, wlast_hs, cyc;
        @(negedge aclk);
        wr_addr = 32'h2000; wr_len = 8'd255; start_write = 1;
        #1;
        checks++; if (cmd_ack !== 1'b1) begin failures++; $display("FAIL wr_cmd_ack got=%0b exp=1", cmd_ack); end
        @(negedge aclk);
        start_write = 0; awready = 0;
        #1;
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h2000 || awlen !== 8'd255) begin failures++; $display("FAIL wr_aw got=%0b/%0h/%0h exp=1/2000/ff", awvalid, awaddr, awlen); end
        checks++; if (wvalid !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL wr_w_outside got=%0b%0b exp=00", wvalid, wr_ready); end
        @(negedge aclk);
        awready = 1;
        #1;
        checks++; if (awvalid !== 1'b1) begin failures++; $display("FAIL wr_aw_hold got=%0b exp=1", awvalid); end
        @(negedge aclk);
        awready = 0;
        dut_hs = 0; wlast_hs = 0; cyc = 0;
        while (dut_hs < 256 && cyc < 2000) begin
            wr_valid = cyc[0]; wready = (cyc % 3) != 2; wr_data = 32'h5500_0000 + dut_hs;
            #1;
            if (wvalid !== wr_valid) begin checks++; failures++; $display("FAIL wr_wvalid cyc%0d got=%0b exp=%0b", cyc, wvalid, wr_valid); end
            if (wvalid === 1'b1 && wr_ready === 1'b1) begin
                checks++; if (wlast !== (dut_hs == 255)) begin failures++; $display("FAIL wr_wlast beat%0d got=%0b exp=%0b", dut_hs, wlast, dut_hs == 255); end
                if (wlast === 1'b1) wlast_hs++;
                dut_hs++;
            end
            @(negedge aclk);
            cyc++;
        end
        wr_valid = 0; wready = 0;
        #1;
        checks++; if (dut_hs != 256) begin failures++; $display("FAIL wr_beats got=%0d exp=256", dut_hs); end
        checks++; if (wlast_hs != 1) begin failures++; $display("FAIL wr_wlast_count got=%0d exp=1", wlast_hs); end
        checks++; if (bready !== 1'b1 || awvalid !== 1'b0) begin failures++; $display("FAIL wr_b_state got=%0b%0b exp=10", bready, awvalid); end
        bvalid = 1; bresp = 2'd2;
        @(negedge aclk);
        bvalid = 0; bresp = 0;
        #1;
        checks++; if (done !== 1'b1 || done_is_write !== 1'b1) begin failures++; $display("FAIL wr_done got=%0b/%0b exp=1/1", done, done_is_write); end
        checks++; if (done_resp !== 2'd2) begin failures++; $display("FAIL wr_done_resp got=%0h exp=2", done_resp); end
        checks++; if (bready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL wr_after_b got=%0b%0b exp=00", bready, busy); end
    endtask

    // Both starts held with an always-ready slave; the direction of each grant is read from arvalid/awvalid.
    task automatic test_arbitration();
        logic [2:0] exp_dir;
        int got_n, acks;
        logic prev_ack;
`ifdef AXI_MASTER_CTRL_RR_EN
        exp_dir = 3'b010;
`else
        exp_dir = 3'b000;
`endif
        @(negedge aclk);
        areset = 1;
        @(negedge aclk);
        areset = 0;
        idle_inputs();
        rd_addr = 32'h300; wr_addr = 32'h400;
        arready = 1; awready = 1; wready = 1; bvalid = 1; rvalid = 1; rlast = 1;
        rd_ready = 1; wr_valid = 1; start_read = 1; start_write = 1;
        got_n = 0; acks = 0; prev_ack = 0;
        for (int cyc = 0; cyc < 60 && got_n < 3; cyc++) begin
            #1;
            if (prev_ack) begin
                checks++; if (awvalid !== exp_dir[got_n] || arvalid !== !exp_dir[got_n]) begin failures++; $display("FAIL arb_grant%0d got=ar%0b/aw%0b exp_write=%0b", got_n, arvalid, awvalid, exp_dir[got_n]); end
                got_n++;
            end
            if (busy === 1'b1 && cmd_ack !== 1'b0) begin checks++; failures++; $display("FAIL arb_ack_while_busy got=%0b exp=0", cmd_ack); end
            if (cmd_ack === 1'b1) begin
                if (acks > 0) begin
                    checks++; if (done !== 1'b1) begin failures++; $display("FAIL arb_back_to_back ack%0d done=%0b exp=1", acks, done); end
                end
                acks++;
            end
            prev_ack = cmd_ack;
            @(negedge aclk);
        end
        checks++; if (got_n != 3) begin failures++; $display("FAIL arb_grants got=%0d exp=3", got_n); end
        idle_inputs();
        areset = 1;
        @(negedge aclk);
        areset = 0;
    endtask

    task automatic test_reset_mid_write();
        @(negedge aclk);
        wr_addr = 32'h500; wr_len = 8'd3; start_write = 1;
        #1;
        checks++; if (cmd_ack !== 1'b1) begin failures++; $display("FAIL mid_cmd_ack got=%0b exp=1", cmd_ack); end
        @(negedge aclk);
        start_write = 0; awready = 1;
        @(negedge aclk);
        awready = 0; wr_valid = 1; wready = 1;
        @(negedge aclk);
        areset = 1;
        #1;
        checks++; if (wvalid !== 1'b0 || awvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset got=w%0b/aw%0b/busy%0b exp=0/0/0", wvalid, awvalid, busy); end
        checks++; if (wr_ready !== 1'b0 || wlast !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_reset_misc got=%0b%0b%0b exp=000", wr_ready, wlast, done); end
        @(negedge aclk);
        wr_valid = 0; wready = 0; areset = 0;
        start_read = 1; rd_addr = 32'h600; rd_len = 8'd0;
        #1;
        checks++; if (cmd_ack !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL mid_regrant got=ack%0b/done%0b exp=1/0", cmd_ack, done); end
        @(negedge aclk);
        start_read = 0; arready = 1;
        #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h600 || arlen !== 8'd0) begin failures++; $display("FAIL mid_ar got=%0b/%0h/%0h exp=1/600/0", arvalid, araddr, arlen); end
        @(negedge aclk);
        arready = 0; rvalid = 1; rlast = 1; rd_ready = 1; rdata = 32'h1234_5678;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin failures++; $display("FAIL mid_rbeat got=%0b/%0h exp=1/12345678", rd_valid, rd_data); end
        @(negedge aclk);
        rvalid = 0; rlast = 0; rd_ready = 0;
        #1;
        checks++; if (done !== 1'b1 || done_is_write !== 1'b0 || done_resp !== 2'b00) begin failures++; $display("FAIL mid_done got=%0b/%0b/%0h exp=1/0/0", done, done_is_write, done_resp); end
    endtask

    initial begin
        idle_inputs();
        areset = 1;
        test_reset();
        test_read();
        test_read_resp();
        test_write_256();
        test_arbitration();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
